pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised stall/flush controller for the NPC pipeline: NREQ prioritised hazard requests, each carrying its own
//  per-stage stall and flush masks, arbitrated into NSTAGE stall/flush vectors. Adds a deferred-flush slot so a
//  redirect losing arbitration (e.g. jump under a MEM RAM stall) is replayed, a reset-exit flush, a stall watchdog
//  and saturating performance counters. Sits beside the pipeline registers; outputs drive PC..MEM_WB enables.
// PARAMETERS
//  NSTAGE     6     pipeline boundaries; bit0=PC,1=Pre_IF,2=IF_ID,3=ID_EX,4=EX_MEM,5=MEM_WB
//  NREQ       8     hazard request sources; index 0 = highest priority
//  DEFER_MASK 8'h0C request indices whose flush is deferrable when they lose arbitration
//  WDOG_LIM   1024  consecutive stalled cycles before watchdog fires (>=2)
//  CNT_W      32    performance counter width
// PORTS
//  clk            in   1              clock, all state on rising edge
//  rst            in   1              asynchronous, active-low reset (0 = reset)
//  req_valid_i    in   NREQ           per-source request, level
//  req_stall_i    in   NREQ*NSTAGE    stall mask of source k at [k*NSTAGE +: NSTAGE]
//  req_flush_i    in   NREQ*NSTAGE    flush mask of source k, same packing
//  wdog_clr_i     in   1              clears sticky watchdog flag
//  stall_o        out  NSTAGE         stall per boundary
//  flush_o        out  NSTAGE         flush per boundary
//  win_idx_o      out  $clog2(NREQ)   index of winning request (0 when none)
//  win_vld_o      out  1              a request won this cycle
//  wdog_o         out  1              sticky watchdog flag
//  stall_cnt_o    out  CNT_W          cycles with stall_o != 0, saturating
//  flush_cnt_o    out  CNT_W          cycles with flush_o != 0, saturating
// BEHAVIOUR
//  - Arbitration is combinational, zero latency: winner = lowest index k with req_valid_i[k]. stall_o/flush_o =
//    masks of winner; none valid -> stall_o=0, flush_o=0 (before replay/init terms below).
//  - Deferred slot (pend_vld, pend_idx, pend_mask), registered: each cycle, if a DEFER_MASK source j is valid and
//    not the winner, slot captures j's flush mask; if already occupied, masks OR and pend_idx = min(old, j).
//  - Replay: in a cycle where slot occupied and (no winner or winner index > pend_idx), flush_o |= pend_mask and
//    slot clears next edge. Same cycle a new loser capture takes precedence: slot reloads with new value only.
//  - Deferrable source winning with index == pend_idx clears slot (serviced directly, no double flush).
//  - Init: init_q set by reset, cleared on first clk after rst rises. While rst=0 or init_q=1: stall_o=0,
//    flush_o={NSTAGE{1}}, win_vld_o=0; requests ignored, slot not loaded.
//  - FSM (2 bits): RUN -> HOLD when stall_o!=0; HOLD -> RUN when stall_o==0 (wdog count resets to 0);
//    HOLD counts consecutive stalled cycles; count reaching WDOG_LIM -> WDOG, wdog_o<=1.
//    WDOG behaves as HOLD for stall/flush (watchdog never alters pipeline control), stays until wdog_clr_i;
//    on clr -> HOLD if stalled else RUN, count=0. wdog_clr_i and firing same cycle: clear wins.
//  - Counters increment by 1 at edge when condition true, saturate at all-ones; reset only by rst.
//  - Reset values: state=RUN, pend_vld=0, pend_mask=0, pend_idx=0, wdog_o=0, counters=0, init_q=1,
//    win_idx_o=0, win_vld_o=0, stall_o=0, flush_o=all ones.
//  - Reset mid-operation: slot, FSM, counters drop asynchronously; no replay survives reset.
// TESTING
//  1 Reset release, no reqs: flush_o=6'h3F during rst=0 and 1 cycle after; then 6'h00, stall_o=0, counters 0.
//  2 req0 (stall 6'h1F, flush 6'h20) with req3 (flush 6'h0E): stall_o=1F, flush_o=20, win_idx_o=0; 4 cycles, then
//    req0 drops same cycle req3 drops -> flush_o=0E that cycle (replay), slot empty next, stall_cnt_o=4.
//  3 req2+req3 both lose to req0: pend_idx=2, pend_mask=OR; req3 then wins alone -> replay fires (3>2), flush_o
//    = req3 mask | pend_mask, exactly once.
//  4 req3 loses once, then wins alone next cycle: slot cleared, flush_o = req3 mask only, flush_cnt_o +1.
//  5 WDOG_LIM=4, req0 stalling 4 cycles: wdog_o=1 after 4th edge, stays after req0 drops; wdog_clr_i -> 0.
//  6 Counter saturation (CNT_W=4): 20 stalled cycles -> stall_cnt_o=4'hF; rst mid-stall clears all state.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush controller for the NPC pipeline. NREQ prioritised hazard sources
// each present their own per-boundary stall and flush masks. The lowest valid
// index wins and its masks drive the pipeline boundaries combinationally.
//
// A deferred-flush slot remembers the flush of a deferrable source that lost
// arbitration, for example a jump redirect under a MEM RAM stall. The flush is
// replayed once the higher-priority hazard is gone. The slot is dropped when
// that same source later wins directly.
//
// The block also provides:
//   - a reset-exit flush of every boundary,
//   - a sticky stall watchdog,
//   - saturating stall and flush cycle counters.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   req_valid_i  per-source request level, index 0 = highest priority
//   req_stall_i  stall mask of source k at [k*NSTAGE +: NSTAGE]
//   req_flush_i  flush mask of source k, same packing
//   wdog_clr_i   clears the sticky watchdog flag
//   stall_o      stall per boundary (bit0 = PC ... bit5 = MEM_WB)
//   flush_o      flush per boundary
//   win_idx_o    index of the winning request (0 when none)
//   win_vld_o    a request won this cycle
//   wdog_o       sticky watchdog flag
//   stall_cnt_o  cycles with stall_o != 0, saturating
//   flush_cnt_o  cycles with flush_o != 0, saturating
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int              NSTAGE     = 6,
    parameter int              NREQ       = 8,
    parameter logic [NREQ-1:0] DEFER_MASK = NREQ'(8'h0C),
    parameter int              WDOG_LIM   = 1024,
    parameter int              CNT_W      = 32,
    localparam int             IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*NSTAGE-1:0]   req_stall_i,
    input  logic [NREQ*NSTAGE-1:0]   req_flush_i,
    input  logic                     wdog_clr_i,
    output logic [NSTAGE-1:0]        stall_o,
    output logic [NSTAGE-1:0]        flush_o,
    output logic [IDX_W-1:0]         win_idx_o,
    output logic                     win_vld_o,
    output logic                     wdog_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    localparam int WCNT_W = $clog2(WDOG_LIM + 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_WDOG = 2'd2
    } state_t;

    // Per-source masks unpacked for indexed selection
    logic [NSTAGE-1:0] stall_m [NREQ];
    logic [NSTAGE-1:0] flush_m [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign stall_m[gi] = req_stall_i[gi*NSTAGE +: NSTAGE];
            assign flush_m[gi] = req_flush_i[gi*NSTAGE +: NSTAGE];
        end
    endgenerate

    logic              init_q;
    logic              active;
    logic              any_req;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;

    logic              pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [NSTAGE-1:0] pend_mask_q, pend_mask_d;

    logic              cap_vld;
    logic [IDX_W-1:0]  cap_idx;
    logic [NSTAGE-1:0] cap_mask;
    logic              replay;
    logic              serviced;

    state_t            state_q;
    logic [WCNT_W-1:0] wdog_cnt_q;
    logic              wdog_q;
    logic              stalled;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // The controller only arbitrates once reset is released and the
    // reset-exit flush cycle has passed.
    assign active  = rst & ~init_q;
    assign any_req = |req_valid_i;
    assign win_vld = active & any_req;

    // Fixed priority: scanning downwards leaves the lowest valid index.
    always_comb begin
        win_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                win_idx = IDX_W'(k);
            end
        end
    end

    // Deferrable losers this cycle: OR their flush masks and keep the
    // smallest index.
    always_comb begin
        cap_vld  = 1'b0;
        cap_idx  = '0;
        cap_mask = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (active && DEFER_MASK[k] && req_valid_i[k] && (IDX_W'(k) != win_idx)) begin
                cap_vld  = 1'b1;
                cap_idx  = IDX_W'(k);
                cap_mask = cap_mask | flush_m[k];
            end
        end
    end

    // Replay once nothing of higher priority than the deferred source
    // holds the pipeline.
    assign replay = active & pend_vld_q & (~any_req | (win_idx > pend_idx_q));

    // The deferred source winning directly services its own flush.
    assign serviced = active & pend_vld_q & any_req & (win_idx == pend_idx_q);

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_idx_d  = pend_idx_q;
        pend_mask_d = pend_mask_q;
        if (cap_vld) begin
            pend_vld_d = 1'b1;
            if (pend_vld_q && !(replay || serviced)) begin
                pend_mask_d = pend_mask_q | cap_mask;
                pend_idx_d  = (cap_idx < pend_idx_q) ? cap_idx : pend_idx_q;
            end else begin
                // Consumed content is not merged; only the new losers load.
                pend_mask_d = cap_mask;
                pend_idx_d  = cap_idx;
            end
        end else if (replay || serviced) begin
            pend_vld_d  = 1'b0;
            pend_idx_d  = '0;
            pend_mask_d = '0;
        end
    end

    assign stall_o   = win_vld ? stall_m[win_idx] : '0;
    assign flush_o   = !active ? '1
                     : ((win_vld ? flush_m[win_idx] : '0) | (replay ? pend_mask_q : '0));
    assign win_idx_o = win_vld ? win_idx : '0;
    assign win_vld_o = win_vld;
    assign wdog_o    = wdog_q;

    assign stalled   = |stall_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_vld_q  <= 1'b0;
            pend_idx_q  <= '0;
            pend_mask_q <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_idx_q  <= pend_idx_d;
            pend_mask_q <= pend_mask_d;
        end
    end

    // Watchdog FSM. It only observes stall_o and never feeds back into
    // the pipeline control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stalled) begin
                        state_q    <= ST_HOLD;
                        wdog_cnt_q <= WCNT_W'(1);
                    end else begin
                        wdog_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!stalled) begin
                        state_q    <= ST_RUN;
                        wdog_cnt_q <= '0;
                    end else if (wdog_cnt_q >= WCNT_W'(WDOG_LIM - 1)) begin
                        if (wdog_clr_i) begin
                            // A clear arriving with the firing cycle wins
                            // and restarts the count.
                            wdog_cnt_q <= '0;
                        end else begin
                            state_q <= ST_WDOG;
                            wdog_q  <= 1'b1;
                        end
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + WCNT_W'(1);
                    end
                end
                ST_WDOG: begin
                    if (wdog_clr_i) begin
                        state_q    <= stalled ? ST_HOLD : ST_RUN;
                        wdog_cnt_q <= '0;
                        wdog_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    wdog_cnt_q <= '0;
                    wdog_q     <= 1'b0;
                end
            endcase
        end
    end

    // The reset-exit flush is not a hazard event, so counting waits for
    // arbitration to be active.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (active && stalled && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (active && (|flush_o) && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Bench for pipeline_hazard_ctrl, built with a 4-cycle watchdog and 4-bit
// counters so that firing and saturation are reachable quickly.
//
// It combines:
//   - a directed vector table,
//   - hand-written multi-cycle sequences,
//   - randomized traffic checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int NS = 6;
    localparam int NR = 8;
    localparam int WL = 4;
    localparam int CW = 4;
    localparam logic [NR-1:0] DEFER = 8'h0C;

    // Fixed masks for directed tests (source 7 first ... source 0 last)
    localparam logic [NR*NS-1:0] STALL_FIX = {6'h01, 6'h01, 6'h01, 6'h01,
                                              6'h00, 6'h00, 6'h03, 6'h1F};
    localparam logic [NR*NS-1:0] FLUSH_FIX = {6'h00, 6'h00, 6'h00, 6'h00,
                                              6'h0E, 6'h11, 6'h00, 6'h20};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*NS-1:0]  req_stall = '0;
    logic [NR*NS-1:0]  req_flush = '0;
    logic              wdog_clr  = 1'b0;
    logic [NS-1:0]     stall_o, flush_o;
    logic [2:0]        win_idx_o;
    logic              win_vld_o, wdog_o;
    logic [CW-1:0]     stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .NSTAGE     (NS),
        .NREQ       (NR),
        .DEFER_MASK (DEFER),
        .WDOG_LIM   (WL),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_stall_i (req_stall),
        .req_flush_i (req_flush),
        .wdog_clr_i  (wdog_clr),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .win_idx_o   (win_idx_o),
        .win_vld_o   (win_vld_o),
        .wdog_o      (wdog_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit            m_init;
    bit            m_pend_v;
    int            m_pend_i;
    logic [NS-1:0] m_pend_m;
    int            m_run;       // consecutive stalled cycles seen
    bit            m_wdog;
    int            m_scnt;
    int            m_fcnt;

    // Per-cycle expectations
    int            e_win;       // -1 when no winner
    logic [NS-1:0] e_stall;
    logic [NS-1:0] e_flush;
    bit            e_replay;

    function automatic logic [NS-1:0] fld(input logic [NR*NS-1:0] v, input int k);
        return v[k*NS +: NS];
    endfunction

    task automatic model_reset();
        m_init   = 1'b1;
        m_pend_v = 1'b0;
        m_pend_i = 0;
        m_pend_m = '0;
        m_run    = 0;
        m_wdog   = 1'b0;
        m_scnt   = 0;
        m_fcnt   = 0;
    endtask

    task automatic model_eval();
        e_win    = -1;
        e_stall  = '0;
        e_flush  = '0;
        e_replay = 1'b0;
        if (m_init) begin
            e_flush = '1;
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (req_valid[k] && e_win < 0) e_win = k;
            end
            if (e_win >= 0) begin
                e_stall = fld(req_stall, e_win);
                e_flush = fld(req_flush, e_win);
            end
            e_replay = m_pend_v && (e_win < 0 || e_win > m_pend_i);
            if (e_replay) e_flush = e_flush | m_pend_m;
        end
    endtask

    task automatic model_edge();
        logic [NS-1:0] lm;
        int            lmin;
        bit            cleared;
        if (m_init) begin
            m_init = 1'b0;
            return;
        end
        if (e_stall != 0 && m_scnt < (1 << CW) - 1) m_scnt++;
        if (e_flush != 0 && m_fcnt < (1 << CW) - 1) m_fcnt++;

        lm   = '0;
        lmin = -1;
        for (int k = NR - 1; k >= 0; k--) begin
            if (DEFER[k] && req_valid[k] && k != e_win) begin
                lm   = lm | fld(req_flush, k);
                lmin = k;
            end
        end
        cleared = e_replay || (m_pend_v && e_win == m_pend_i);
        if (lmin >= 0) begin
            if (m_pend_v && !cleared) begin
                m_pend_m = m_pend_m | lm;
                if (lmin < m_pend_i) m_pend_i = lmin;
            end else begin
                m_pend_v = 1'b1;
                m_pend_m = lm;
                m_pend_i = lmin;
            end
        end else if (cleared) begin
            m_pend_v = 1'b0;
            m_pend_m = '0;
            m_pend_i = 0;
        end

        if (m_wdog) begin
            if (wdog_clr) begin
                m_wdog = 1'b0;
                m_run  = 0;
            end
        end else if (e_stall != 0) begin
            if (m_run + 1 >= WL) begin
                if (wdog_clr) m_run = 0;
                else m_wdog = 1'b1;
            end else begin
                m_run++;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic compare_model();
        chk("mdl_stall", 32'(stall_o), 32'(e_stall));
        chk("mdl_flush", 32'(flush_o), 32'(e_flush));
        chk("mdl_idx",   32'(win_idx_o), (e_win < 0) ? 32'd0 : 32'(e_win));
        chk("mdl_vld",   32'(win_vld_o), (e_win < 0) ? 32'd0 : 32'd1);
        chk("mdl_wdog",  32'(wdog_o), 32'(m_wdog));
        chk("mdl_scnt",  32'(stall_cnt_o), 32'(m_scnt));
        chk("mdl_fcnt",  32'(flush_cnt_o), 32'(m_fcnt));
    endtask

    // One clock: sample at the falling edge, advance the model at the
    // rising edge, then leave 1 time unit for the next input drive.
    task automatic cycle(input bit use_mdl);
        @(negedge clk);
        model_eval();
        if (use_mdl) begin
            compare_model();
            txn++;
            $display("txn %0d valid=%h stall=%h flush=%h idx=%0d vld=%0b wdog=%0b scnt=%0d fcnt=%0d",
                     txn, req_valid, stall_o, flush_o, win_idx_o, win_vld_o, wdog_o,
                     stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Reset asserted asynchronously with live requests (they must be
    // ignored). Then one init cycle is checked, and the bus is left idle.
    task automatic apply_reset();
        rst       = 1'b0;
        req_valid = NR'($urandom);
        req_stall = {$urandom, $urandom};
        req_flush = {$urandom, $urandom};
        wdog_clr  = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", 32'(stall_o), 32'h00);
        chk("rst_flush", 32'(flush_o), 32'h3F);
        chk("rst_vld",   32'(win_vld_o), 32'd0);
        chk("rst_idx",   32'(win_idx_o), 32'd0);
        chk("rst_wdog",  32'(wdog_o), 32'd0);
        chk("rst_scnt",  32'(stall_cnt_o), 32'd0);
        chk("rst_fcnt",  32'(flush_cnt_o), 32'd0);
        $display("reset asserted");
        @(posedge clk);
        #2;
        rst = 1'b1;
        cycle(1'b1);
        req_valid = '0;
        req_stall = STALL_FIX;
        req_flush = FLUSH_FIX;
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic          clr;
        logic [NS-1:0] stall;
        logic [NS-1:0] flush;
        logic [2:0]    idx;
        logic          vld;
        logic          wdog;
        logic [CW-1:0] scnt;
        logic [CW-1:0] fcnt;
    } vec_t;

    vec_t tbl [22];

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        //           valid  clr   stall  flush  idx   vld   wdog  scnt  fcnt
        tbl[0]  = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[1]  = '{8'h09, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[2]  = '{8'h09, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd1, 4'd1};
        tbl[3]  = '{8'h09, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd2, 4'd2};
        tbl[4]  = '{8'h09, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd3, 4'd3};
        tbl[5]  = '{8'h00, 1'b0, 6'h00, 6'h0E, 3'd0, 1'b0, 1'b1, 4'd4, 4'd4};
        tbl[6]  = '{8'h00, 1'b1, 6'h00, 6'h00, 3'd0, 1'b0, 1'b1, 4'd4, 4'd5};
        tbl[7]  = '{8'h0D, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd4, 4'd5};
        tbl[8]  = '{8'h08, 1'b0, 6'h00, 6'h1F, 3'd3, 1'b1, 1'b0, 4'd5, 4'd6};
        tbl[9]  = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd5, 4'd7};
        tbl[10] = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd5, 4'd7};
        tbl[11] = '{8'h09, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd5, 4'd7};
        tbl[12] = '{8'h08, 1'b0, 6'h00, 6'h0E, 3'd3, 1'b1, 1'b0, 4'd6, 4'd8};
        tbl[13] = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd6, 4'd9};
        tbl[14] = '{8'h06, 1'b0, 6'h03, 6'h00, 3'd1, 1'b1, 1'b0, 4'd6, 4'd9};
        tbl[15] = '{8'h02, 1'b0, 6'h03, 6'h00, 3'd1, 1'b1, 1'b0, 4'd7, 4'd9};
        tbl[16] = '{8'h00, 1'b0, 6'h00, 6'h11, 3'd0, 1'b0, 1'b0, 4'd8, 4'd9};
        tbl[17] = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd8, 4'd10};
        tbl[18] = '{8'h05, 1'b0, 6'h1F, 6'h20, 3'd0, 1'b1, 1'b0, 4'd8, 4'd10};
        tbl[19] = '{8'h0C, 1'b0, 6'h00, 6'h11, 3'd2, 1'b1, 1'b0, 4'd9, 4'd11};
        tbl[20] = '{8'h00, 1'b0, 6'h00, 6'h0E, 3'd0, 1'b0, 1'b0, 4'd9, 4'd12};
        tbl[21] = '{8'h00, 1'b0, 6'h00, 6'h00, 3'd0, 1'b0, 1'b0, 4'd9, 4'd13};

        // Reset release with no requests.
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Directed vector table: arbitration, replay, servicing, and
        // reload-only precedence.
        for (int i = 0; i < 22; i++) begin
            req_valid = tbl[i].valid;
            wdog_clr  = tbl[i].clr;
            @(negedge clk);
            model_eval();
            chk("vec_stall", 32'(stall_o),     32'(tbl[i].stall));
            chk("vec_flush", 32'(flush_o),     32'(tbl[i].flush));
            chk("vec_idx",   32'(win_idx_o),   32'(tbl[i].idx));
            chk("vec_vld",   32'(win_vld_o),   32'(tbl[i].vld));
            chk("vec_wdog",  32'(wdog_o),      32'(tbl[i].wdog));
            chk("vec_scnt",  32'(stall_cnt_o), 32'(tbl[i].scnt));
            chk("vec_fcnt",  32'(flush_cnt_o), 32'(tbl[i].fcnt));
            $display("vec %0d valid=%h stall=%h flush=%h idx=%0d wdog=%0b scnt=%0d fcnt=%0d",
                     i, req_valid, stall_o, flush_o, win_idx_o, wdog_o, stall_cnt_o, flush_cnt_o);
            @(posedge clk);
            model_edge();
            #1;
        end
        wdog_clr = 1'b0;

        // Watchdog: fire after 4 stalled edges, stay sticky, and clear.
        // Then a clear arriving with the firing cycle wins.
        apply_reset();
        req_valid = 8'h01;
        repeat (3) cycle(1'b1);
        chk("wd_pre", 32'(wdog_o), 32'd0);
        cycle(1'b1);
        chk("wd_fire", 32'(wdog_o), 32'd1);
        req_valid = 8'h00;
        repeat (2) cycle(1'b1);
        chk("wd_sticky", 32'(wdog_o), 32'd1);
        wdog_clr = 1'b1;
        cycle(1'b1);
        wdog_clr = 1'b0;
        chk("wd_clr", 32'(wdog_o), 32'd0);
        req_valid = 8'h01;
        repeat (3) cycle(1'b1);
        wdog_clr = 1'b1;
        cycle(1'b1);
        wdog_clr = 1'b0;
        chk("wd_clr_wins", 32'(wdog_o), 32'd0);
        repeat (3) cycle(1'b1);
        chk("wd_restart", 32'(wdog_o), 32'd0);
        cycle(1'b1);
        chk("wd_refire", 32'(wdog_o), 32'd1);

        // Saturation, then reset mid-stall with the deferred slot loaded.
        apply_reset();
        req_valid = 8'h09;
        repeat (20) cycle(1'b1);
        chk("sat_scnt", 32'(stall_cnt_o), 32'hF);
        chk("sat_fcnt", 32'(flush_cnt_o), 32'hF);
        apply_reset();
        @(negedge clk);
        model_eval();
        chk("no_replay_flush", 32'(flush_o), 32'h00);
        chk("no_replay_scnt",  32'(stall_cnt_o), 32'd0);
        chk("no_replay_wdog",  32'(wdog_o), 32'd0);
        $display("post-reset flush=%h scnt=%0d", flush_o, stall_cnt_o);
        @(posedge clk);
        model_edge();
        #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                apply_reset();
            end else begin
                req_valid = ($urandom_range(0, 3) == 0) ? 8'h00
                          : NR'($urandom & $urandom);
                req_stall = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) req_stall = '0;
                req_flush = {$urandom, $urandom};
                wdog_clr  = ($urandom_range(0, 7) == 0);
                cycle(1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
